div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameters: none; the data width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request strobe, sampled only in IDLE.
REQ-005 dividend_i  input  32  rs1 operand, captured at accept.
REQ-006 divisor_i  input  32  rs2 operand, captured at accept.
REQ-007 op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; captured at accept.
REQ-008 reg_waddr_i  input  5  destination register, captured at accept.
REQ-009 flush_i  input  1  pipeline flush (ex jump); aborts the operation in progress.
REQ-010 busy_o  output  1  high whenever state is not IDLE.
REQ-011 ready_o  output  1  one-cycle completion pulse.
REQ-012 result_o  output  32  quotient or remainder; valid with ready_o and held afterwards.
REQ-013 reg_waddr_o  output  5  captured destination register, valid with ready_o.

Function
REQ-014 State machine SHALL have three states: IDLE, CALC, END.
REQ-015 Accept: in IDLE with start_i=1 and flush_i=0, capture all inputs and go to CALC; start_i in any other state SHALL be ignored.
REQ-016 Signed ops (DIV, REM) SHALL divide magnitudes. The quotient is negated when the operand signs differ. The remainder takes the sign of the dividend.
REQ-017 CALC SHALL run a radix-2 restoring iteration with a 5-bit counter, one quotient bit per cycle, for exactly 32 cycles, then go to END.
REQ-018 Latency: with accept in cycle 0, CALC occupies cycles 1-32 and END is cycle 33. ready_o SHALL be 1 in cycle 33 only, then the block returns to IDLE.
REQ-019 A new start SHALL be accepted no earlier than cycle 34.
REQ-020 Divisor zero: quotient SHALL be 0xFFFFFFFF (DIV and DIVU), remainder SHALL be the dividend.
REQ-021 Overflow, 0x80000000 / 0xFFFFFFFF signed: quotient SHALL be 0x80000000, remainder SHALL be 0.
REQ-022 flush_i=1 in CALC or END SHALL return to IDLE on the next edge. ready_o SHALL stay 0 and result_o SHALL be unchanged.
REQ-023 flush_i and start_i both high in IDLE: flush wins and no accept occurs.
REQ-024 result_o and reg_waddr_o SHALL hold their values until the next ready_o pulse.

Reset
REQ-025 rst=0 SHALL force IDLE immediately, regardless of the clock.
REQ-026 Reset values: busy_o=0, ready_o=0, result_o=0, reg_waddr_o=0, counter=0.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no ready_o pulse follows release.
REQ-028 Operation resumes on the first clock edge after rst returns high.

Configuration
REQ-029 Macro DIV_EARLY_OUT_EN, when defined, enables an early-out path.
REQ-030 With DIV_EARLY_OUT_EN defined: divisor zero, or unsigned divisor magnitude greater than dividend magnitude, goes directly from IDLE to END. ready_o is then asserted in cycle 1.
REQ-031 Without DIV_EARLY_OUT_EN: every operation takes the full 33-cycle latency.
REQ-032 result_o SHALL be bit-identical with and without the macro.

Verification
REQ-033 DIV 0xFFFFFFF9 / 0x00000002 -> result_o=0xFFFFFFFD, ready_o in cycle 33.
REQ-034 REM 0xFFFFFFF9 / 0x00000002 -> result_o=0xFFFFFFFF.
REQ-035 DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF; a back-to-back start held high from cycle 1 is accepted only at cycle 34.
REQ-036 DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 0x00000005. Ready arrives in cycle 1 with the macro defined and in cycle 33 without it.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000.
REQ-038 flush_i pulse in cycle 10 -> busy_o=0 in cycle 11, no ready_o, result_o unchanged. rst=0 in cycle 20 of another operation -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_iter.sv
// Iterative 32-bit RISC-V M-extension divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Optional `DIV_EARLY_OUT_EN skips the iteration when the quotient is trivially known (zero divisor or divisor > dividend).
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [2:0]  op_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  reg_waddr_o
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, CALC, END} state_t;

  function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] mag, input logic neg);
    return neg ? (~mag) + DATA_W'(1) : mag;
  endfunction

  state_t state, state_nx;
  logic [4:0] cnt;

  logic signed [DATA_W-1:0] dvd_s, dvs_s;
  logic [DATA_W-1:0] dvd_mag, dvs_mag;
  logic is_signed, dvd_neg, dvs_neg, div_zero, early_out, accept;

  logic [DATA_W-1:0] rem_p1, quo_p1, dvs_p1;
  logic              neg_q_p1, neg_r_p1, sel_rem_p1;
  logic [4:0]        waddr_p1;
  logic [DATA_W+1:0] trial;
  logic              borrow;
  logic [DATA_W-1:0] res_fin;
  logic              vld_p1;

  logic [DATA_W-1:0] result_p2;
  logic [4:0]        waddr_p2;
  logic [1:0]        unused_bits;

  assign dvd_s     = dividend_i;
  assign dvs_s     = divisor_i;
  assign is_signed = ~op_i[0];
  assign dvd_neg   = is_signed & (dvd_s < 0);
  assign dvs_neg   = is_signed & (dvs_s < 0);
  assign dvd_mag   = sign_fix(dividend_i, dvd_neg);
  assign dvs_mag   = sign_fix(divisor_i, dvs_neg);
  assign div_zero  = (divisor_i == '0);
  assign accept    = (state == IDLE) & start_i & ~flush_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = div_zero | (dvs_mag > dvd_mag);
`else
  assign early_out = 1'b0;
`endif

  // Restoring step: shift the next dividend bit into the partial remainder and try subtracting.
  assign trial  = {1'b0, rem_p1, quo_p1[DATA_W-1]} - {2'b00, dvs_p1};
  assign borrow = trial[DATA_W+1];

  // A zero divisor never negates: the all-ones quotient must survive signed ops.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvs_p1     <= dvs_mag;
      neg_q_p1   <= (dvd_neg ^ dvs_neg) & ~div_zero;
      neg_r_p1   <= dvd_neg;
      sel_rem_p1 <= op_i[1];
      waddr_p1   <= reg_waddr_i;
      if (early_out) begin
        rem_p1 <= dvd_mag;
        quo_p1 <= div_zero ? '1 : '0;
      end else begin
        rem_p1 <= '0;
        quo_p1 <= dvd_mag;
      end
    end else if (state == CALC) begin
      rem_p1 <= borrow ? {rem_p1[DATA_W-2:0], quo_p1[DATA_W-1]} : trial[DATA_W-1:0];
      quo_p1 <= {quo_p1[DATA_W-2:0], ~borrow};
    end
  end

  // ---- result stage ----
  assign res_fin = sel_rem_p1 ? sign_fix(rem_p1, neg_r_p1) : sign_fix(quo_p1, neg_q_p1);
  assign vld_p1  = (state == END) & ~flush_i;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = early_out ? END : CALC;
      CALC:    if (flush_i) state_nx = IDLE;
               else if (cnt == 5'd31) state_nx = END;
      END:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      result_p2 <= '0;
      waddr_p2  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == CALC && !flush_i) ? cnt + 5'd1 : 5'd0;
      if (vld_p1) begin
        result_p2 <= res_fin;
        waddr_p2  <= waddr_p1;
      end
    end
  end

  assign busy_o      = (state != IDLE);
  assign ready_o     = vld_p1;
  assign result_o    = vld_p1 ? res_fin : result_p2;
  assign reg_waddr_o = vld_p1 ? waddr_p1 : waddr_p2;
  assign unused_bits = {op_i[2], trial[DATA_W]};

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: driver queues expected results, monitor checks each ready_o pulse (value, waddr, cycle).
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [31:0] dividend_i, divisor_i;
  logic [2:0]  op_i;
  logic [4:0]  reg_waddr_i;
  logic        busy_o, ready_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_wa = '0;

  div_iter dut (
    .clk(clk), .rst(rst), .start_i(start_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .op_i(op_i), .reg_waddr_i(reg_waddr_i), .flush_i(flush_i), .busy_o(busy_o),
    .ready_o(ready_o), .result_o(result_o), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(input bit early);
`ifdef DIV_EARLY_OUT_EN
    return early ? 1 : 33;
`else
    return 33 + (early ? 0 : 0);
`endif
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (ready_o === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ready: got ready_o=1 result %h, expected no pulse (cycle %0d)", result_o, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result_o, e.res);
          chk("waddr", 32'(reg_waddr_o), 32'(e.wa));
          chk("ready_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_o !== 1'b0) chk("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] exp, input bit early);
    drive(op, a, b, wa);
    start_i = 1'b1;
    sb.push_back('{res: exp, wa: wa, cyc: cyc + lat(early)});
    last_res = exp;
    last_wa  = wa;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle();
  endtask

  initial begin
    int c0;
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    drive(DIV, '0, '0, '0);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_result", result_o, 0);
    chk("rst_waddr", 32'(reg_waddr_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // directed vectors: op, dividend, divisor, waddr, expected, early-out eligible
    issue(DIV,  32'hFFFF_FFF9, 32'h2,          5'd1,  32'hFFFF_FFFD, 1'b0);
    issue(REM,  32'hFFFF_FFF9, 32'h2,          5'd2,  32'hFFFF_FFFF, 1'b0);
    issue(DIV,  32'h5,         32'h0,          5'd5,  32'hFFFF_FFFF, 1'b1);
    issue(REM,  32'h5,         32'h0,          5'd6,  32'h0000_0005, 1'b1);
    issue(DIV,  32'hFFFF_FFFB, 32'h0,          5'd13, 32'hFFFF_FFFF, 1'b1);
    issue(REM,  32'hFFFF_FFFB, 32'h0,          5'd14, 32'hFFFF_FFFB, 1'b1);
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF,  5'd7,  32'h8000_0000, 1'b0);
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF,  5'd8,  32'h0000_0000, 1'b0);
    issue(DIVU, 32'h7,         32'h9,          5'd9,  32'h0000_0000, 1'b1);
    issue(REM,  32'hFFFF_FFF9, 32'h9,          5'd10, 32'hFFFF_FFF9, 1'b1);
    issue(DIV,  32'd100,       32'hFFFF_FFF9,  5'd11, 32'hFFFF_FFF2, 1'b0);
    issue(REM,  32'd100,       32'hFFFF_FFF9,  5'd12, 32'h0000_0002, 1'b0);
    issue(DIVU, 32'h8000_0000, 32'h3,          5'd15, 32'h2AAA_AAAA, 1'b0);

    // back-to-back: start held high from cycle 1, second op accepted only at cycle 34
    c0 = cyc;
    drive(DIVU, 32'hFFFF_FFFF, 32'h10, 5'd3);
    start_i = 1'b1;
    sb.push_back('{res: 32'h0FFF_FFFF, wa: 5'd3, cyc: c0 + 33});
    @(negedge clk);
    drive(REMU, 32'hFFFF_FFFF, 32'h10, 5'd4);
    sb.push_back('{res: 32'h0000_000F, wa: 5'd4, cyc: c0 + 34 + 33});
    while (cyc < c0 + 34) @(negedge clk);
    chk("b2b_idle_c34", 32'(busy_o), 0);
    @(negedge clk);
    chk("b2b_busy_c35", 32'(busy_o), 1);
    start_i = 1'b0;
    last_res = 32'h0000_000F;
    last_wa  = 5'd4;
    wait_idle();

    // flush in CALC at cycle 10
    c0 = cyc;
    drive(DIVU, 32'd1000, 32'd3, 5'd20);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < c0 + 10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy_c11", 32'(busy_o), 0);
    chk("flush_result_held", result_o, last_res);
    chk("flush_waddr_held", 32'(reg_waddr_o), 32'(last_wa));

    // flush in END suppresses the pulse
    c0 = cyc;
    drive(DIVU, 32'd1000, 32'd3, 5'd21);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < c0 + 33) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_end_busy", 32'(busy_o), 0);
    chk("flush_end_result_held", result_o, last_res);

    // flush and start together in IDLE: no accept
    drive(DIVU, 32'd50, 32'd5, 5'd22);
    start_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_start_no_accept", 32'(busy_o), 0);
    start_i = 1'b0;
    flush_i = 1'b0;

    // async reset at cycle 20 of an operation
    c0 = cyc;
    drive(DIV, 32'hFFFF_FF00, 32'd7, 5'd23);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < c0 + 20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_ready", 32'(ready_o), 0);
    chk("midrst_result", result_o, 0);
    chk("midrst_waddr", 32'(reg_waddr_o), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("postrst_busy", 32'(busy_o), 0);
    chk("postrst_result", result_o, 0);

    issue(DIVU, 32'h64, 32'hA, 5'd31, 32'h0000_000A, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule
